serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 102 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and default width for serial_adder.
package serial_adder_pkg;

    localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: combinational 1-bit full-adder cell used as the serial bit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with valid/ready handshakes.
// Define SERIAL_ADDER_OVF_EN to add the signed overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa, sb, res;
    logic [CW-1:0]    cnt;
    logic             carry, fa_s, fa_c;

    full_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    assign in_ready = state == IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            res       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sa    <= a;
                    sb    <= b;
                    carry <= cin;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res   <= {fa_s, res[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt == LAST ? '0 : cnt + CW'(1);
                    state <= cnt == LAST ? DONE : RUN;
                end
                // First DONE cycle loads the output registers; later cycles wait for the drain.
                DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                    sum       <= res;
                    cout      <= carry;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // Carry into the MSB is the carry flop while the last bit is processed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == RUN && cnt == LAST)
                ovf_r <= carry ^ fa_c;
            if (state == DONE && !out_valid)
                overflow <= ovf_r;
        end
    end
`endif

endmodule
